// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the processor program-counter path:
//   - pc_state_t : 2-bit PC-control FSM encoding (IDLE=0, RUN=1, STALL=2, REDIRECT=3)
//   - XLEN       : datapath width
//   - PC_STEP    : byte distance between sequential instructions
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STALL    = 2'd2,
      ST_REDIRECT = 2'd3
   } pc_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// pc_target_adder
//   Purely combinational computation of the two PC-mux data inputs.
//   Ports:
//     pc     in  XLEN      current program counter
//     offset in  OFFSET_W  signed word offset from the instruction
//     store  out XLEN      pc + 4 (sequential path)
//     pcin   out XLEN      store + sign_extend(offset) * 4 (redirect path)
//   All arithmetic wraps modulo 2^XLEN.
import cpu_pkg::*;

module pc_target_adder #(
   parameter int OFFSET_W = 8
) (
   input  logic [XLEN-1:0]     pc,
   input  logic [OFFSET_W-1:0] offset,
   output logic [XLEN-1:0]     store,
   output logic [XLEN-1:0]     pcin
);

   logic [XLEN-1:0] offset_ext;
   logic [XLEN-1:0] offset_bytes;

   // Word offset -> byte offset: sign-extend first so negative offsets stay negative.
   assign offset_ext   = {{(XLEN-OFFSET_W){offset[OFFSET_W-1]}}, offset};
   assign offset_bytes = {offset_ext[XLEN-3:0], 2'b00};

   assign store = pc + PC_STEP;
   assign pcin  = store + offset_bytes;

endmodule

// File: rtl/pc_update_unit.sv
// pc_update_unit
//   Program-counter control for the simple processor. Holds the PC register,
//   produces the sequential and redirect inputs of the external PC mux,
//   drives the mux select, and loads the mux output back into the PC.
//   Memory stalls freeze the PC; every taken redirect is followed by one
//   fetch-settle bubble during which no instruction is valid.
//   Ports:
//     CLK            in   clock, rising edge
//     RESET_N        in   asynchronous active-low reset
//     BUSYWAIT       in   memory stall, freezes PC
//     JUMP           in   unconditional jump
//     BRANCH         in   branch-if-equal
//     ZERO           in   ALU zero flag
//     OFFSET         in   signed word offset [OFFSET_W]
//     PC_NEXT        in   mux output, next PC value
//     PC             out  current PC
//     STORE          out  PC + 4
//     PCIN           out  branch/jump target
//     SEL            out  mux select, 1 = take PCIN
//     INSTR_VALID    out  current instruction may commit
//     REDIRECT_COUNT out  saturating count of redirects
//                         (only when PC_REDIRECT_COUNT_EN is defined)
import cpu_pkg::*;

module pc_update_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          OFFSET_W = 8
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                BUSYWAIT,
   input  logic                JUMP,
   input  logic                BRANCH,
   input  logic                ZERO,
   input  logic [OFFSET_W-1:0] OFFSET,
   input  logic [XLEN-1:0]     PC_NEXT,
   output logic [XLEN-1:0]     PC,
   output logic [XLEN-1:0]     STORE,
   output logic [XLEN-1:0]     PCIN,
   output logic                SEL,
   output logic                INSTR_VALID
`ifdef PC_REDIRECT_COUNT_EN
   ,
   output logic [15:0]         REDIRECT_COUNT
`endif
);

   pc_state_t       state_reg;
   pc_state_t       state_next;
   logic [XLEN-1:0] pc_reg;
   logic            pc_load;
   logic            taken;

   pc_target_adder #(
      .OFFSET_W (OFFSET_W)
   ) u_target (
      .pc     (pc_reg),
      .offset (OFFSET),
      .store  (STORE),
      .pcin   (PCIN)
   );

   assign PC    = pc_reg;
   assign taken = JUMP | (BRANCH & ZERO);

   // State and PC registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         if (pc_load) begin
            pc_reg <= PC_NEXT;
         end
      end
   end

   // Next-state logic. A stall always wins over a taken redirect; the
   // redirect is only honoured on the cycle BUSYWAIT drops.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (!BUSYWAIT) state_next = ST_RUN;
         end
         ST_RUN, ST_STALL: begin
            if (BUSYWAIT)  state_next = ST_STALL;
            else if (SEL)  state_next = ST_REDIRECT;
            else           state_next = ST_RUN;
         end
         ST_REDIRECT: begin
            if (!BUSYWAIT) state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs. The instruction stays valid across a stall so the decode
   // keeps presenting it until it can commit.
   always_comb begin
      INSTR_VALID = 1'b0;
      pc_load     = 1'b0;
      case (state_reg)
         ST_RUN, ST_STALL: begin
            INSTR_VALID = 1'b1;
            pc_load     = !BUSYWAIT;
         end
         default: begin
            INSTR_VALID = 1'b0;
            pc_load     = 1'b0;
         end
      endcase
      SEL = INSTR_VALID & taken;
   end

`ifdef PC_REDIRECT_COUNT_EN
   logic [15:0] redirect_count_reg;

   // Counts entries into the bubble, not cycles spent in it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         redirect_count_reg <= 16'd0;
      end else if ((state_next == ST_REDIRECT) && (state_reg != ST_REDIRECT)
                   && (redirect_count_reg != 16'hFFFF)) begin
         redirect_count_reg <= redirect_count_reg + 16'd1;
      end
   end

   assign REDIRECT_COUNT = redirect_count_reg;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit
//   Directed bench for pc_update_unit. A bench-side mux closes the loop
//   (PC_NEXT = SEL ? PCIN : STORE), with an override used to seed the PC
//   for the wrap-around case. One line is printed per checked cycle.
`timescale 1ns/1ps

module tb_pc_update_unit;

   logic        clk;
   logic        reset_n;
   logic        busywait;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [7:0]  offset;
   logic [31:0] pc_next;
   logic [31:0] pc;
   logic [31:0] store;
   logic [31:0] pcin;
   logic        sel;
   logic        instr_valid;
`ifdef PC_REDIRECT_COUNT_EN
   logic [15:0] redirect_count;
`endif

   logic        ovr_en;
   logic [31:0] ovr_val;

   int checks;
   int errors;

   assign pc_next = ovr_en ? ovr_val : (sel ? pcin : store);

   pc_update_unit #(
      .RESET_PC (32'h0000_0000),
      .OFFSET_W (8)
   ) dut (
      .CLK            (clk),
      .RESET_N        (reset_n),
      .BUSYWAIT       (busywait),
      .JUMP           (jump),
      .BRANCH         (branch),
      .ZERO           (zero),
      .OFFSET         (offset),
      .PC_NEXT        (pc_next),
      .PC             (pc),
      .STORE          (store),
      .PCIN           (pcin),
      .SEL            (sel),
      .INSTR_VALID    (instr_valid)
`ifdef PC_REDIRECT_COUNT_EN
      ,
      .REDIRECT_COUNT (redirect_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      busywait = 1'b0;
      jump     = 1'b0;
      branch   = 1'b0;
      zero     = 1'b0;
      offset   = 8'h00;
      ovr_en   = 1'b0;
      ovr_val  = 32'h0;
      repeat (3) tick();
      checks++;
      if (pc !== 32'h0 || instr_valid !== 1'b0 || sel !== 1'b0) begin
         $display("FAIL reset_state pc=%h valid=%b sel=%b required pc=0 valid=0 sel=0", pc, instr_valid, sel);
         errors++;
      end
      checks++;
      if (store !== 32'h4 || pcin !== 32'h4) begin
         $display("FAIL reset_adder store=%h pcin=%h required 4 4", store, pcin);
         errors++;
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || pc !== 32'h0) begin
         $display("FAIL idle_after_release valid=%b pc=%h required 0 0", instr_valid, pc);
         errors++;
      end
      $display("reset: pc=%h valid=%b", pc, instr_valid);
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h0) begin
         $display("FAIL first_valid valid=%b pc=%h required 1 0", instr_valid, pc);
         errors++;
      end
      $display("run: pc=%h valid=%b", pc, instr_valid);
      tick();
      checks++;
      if (pc !== 32'h4) begin
         $display("FAIL seq_pc4 pc=%h required 4", pc);
         errors++;
      end
      $display("run: pc=%h", pc);
      tick();
      checks++;
      if (pc !== 32'h8) begin
         $display("FAIL seq_pc8 pc=%h required 8", pc);
         errors++;
      end
      $display("run: pc=%h", pc);
   endtask

   // At PC=8: branch back by 2 words to PC=4.
   task automatic test_taken_branch();
      branch = 1'b1;
      zero   = 1'b1;
      offset = 8'hFE;
      #1;
      checks++;
      if (sel !== 1'b1 || pcin !== 32'h4 || store !== 32'hC) begin
         $display("FAIL taken_sel sel=%b pcin=%h store=%h required 1 4 c", sel, pcin, store);
         errors++;
      end
      $display("branch taken: pc=%h sel=%b pcin=%h", pc, sel, pcin);
      tick();
      checks++;
      if (pc !== 32'h4 || instr_valid !== 1'b0 || sel !== 1'b0) begin
         $display("FAIL taken_bubble pc=%h valid=%b sel=%b required 4 0 0", pc, instr_valid, sel);
         errors++;
      end
      $display("bubble: pc=%h valid=%b", pc, instr_valid);
      branch = 1'b0;
      zero   = 1'b0;
      offset = 8'h00;
      tick();
      checks++;
      if (pc !== 32'h4 || instr_valid !== 1'b1) begin
         $display("FAIL taken_resume pc=%h valid=%b required 4 1", pc, instr_valid);
         errors++;
      end
      tick();
      checks++;
      if (pc !== 32'h8) begin
         $display("FAIL taken_next pc=%h required 8", pc);
         errors++;
      end
      $display("run: pc=%h valid=%b", pc, instr_valid);
   endtask

   // At PC=8: branch with ZERO=0 falls through.
   task automatic test_not_taken_branch();
      branch = 1'b1;
      zero   = 1'b0;
      offset = 8'hFE;
      #1;
      checks++;
      if (sel !== 1'b0) begin
         $display("FAIL not_taken_sel sel=%b required 0", sel);
         errors++;
      end
      tick();
      checks++;
      if (pc !== 32'hC || instr_valid !== 1'b1) begin
         $display("FAIL not_taken_pc pc=%h valid=%b required c 1", pc, instr_valid);
         errors++;
      end
      $display("branch not taken: pc=%h", pc);
      branch = 1'b0;
      offset = 8'h00;
      tick();
      checks++;
      if (pc !== 32'h10) begin
         $display("FAIL seq_pc16 pc=%h required 10", pc);
         errors++;
      end
   endtask

   // At PC=16: jump +4 words under a 3-cycle stall, then a stalled bubble.
   task automatic test_stall_jump();
      busywait = 1'b1;
      jump     = 1'b1;
      offset   = 8'h04;
      #1;
      checks++;
      if (sel !== 1'b1 || pcin !== 32'h24) begin
         $display("FAIL stall_target sel=%b pcin=%h required 1 24", sel, pcin);
         errors++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (pc !== 32'h10 || instr_valid !== 1'b1 || sel !== 1'b1) begin
            $display("FAIL stall_hold%0d pc=%h valid=%b sel=%b required 10 1 1", i, pc, instr_valid, sel);
            errors++;
         end
         $display("stall %0d: pc=%h valid=%b", i, pc, instr_valid);
      end
      busywait = 1'b0;
      tick();
      checks++;
      if (pc !== 32'h24 || instr_valid !== 1'b0 || sel !== 1'b0) begin
         $display("FAIL stall_release pc=%h valid=%b sel=%b required 24 0 0", pc, instr_valid, sel);
         errors++;
      end
      $display("bubble: pc=%h valid=%b", pc, instr_valid);
      jump     = 1'b0;
      offset   = 8'h00;
      busywait = 1'b1;
      tick();
      checks++;
      if (pc !== 32'h24 || instr_valid !== 1'b0) begin
         $display("FAIL bubble_stall pc=%h valid=%b required 24 0", pc, instr_valid);
         errors++;
      end
      busywait = 1'b0;
      tick();
      checks++;
      if (pc !== 32'h24 || instr_valid !== 1'b1) begin
         $display("FAIL stall_resume pc=%h valid=%b required 24 1", pc, instr_valid);
         errors++;
      end
      $display("run: pc=%h valid=%b", pc, instr_valid);
   endtask

   // Seed PC=FFFF_FFFC and check both adders wrap.
   task automatic test_wrap();
      ovr_en  = 1'b1;
      ovr_val = 32'hFFFF_FFFC;
      tick();
      ovr_en  = 1'b0;
      #1;
      checks++;
      if (pc !== 32'hFFFF_FFFC || store !== 32'h0) begin
         $display("FAIL wrap_store pc=%h store=%h required fffffffc 0", pc, store);
         errors++;
      end
      jump   = 1'b1;
      offset = 8'h01;
      #1;
      checks++;
      if (pcin !== 32'h4 || sel !== 1'b1) begin
         $display("FAIL wrap_pcin pcin=%h sel=%b required 4 1", pcin, sel);
         errors++;
      end
      $display("wrap: pc=%h store=%h pcin=%h", pc, store, pcin);
      tick();
      checks++;
      if (pc !== 32'h4 || instr_valid !== 1'b0) begin
         $display("FAIL wrap_jump pc=%h valid=%b required 4 0", pc, instr_valid);
         errors++;
      end
      jump   = 1'b0;
      offset = 8'h00;
   endtask

   // Currently in the REDIRECT bubble after the wrap jump.
   task automatic test_reset_in_redirect();
`ifdef PC_REDIRECT_COUNT_EN
      checks++;
      if (redirect_count !== 16'd3) begin
         $display("FAIL redirect_count count=%0d required 3", redirect_count);
         errors++;
      end
`endif
      reset_n = 1'b0;
      #1;
      checks++;
      if (pc !== 32'h0 || sel !== 1'b0 || instr_valid !== 1'b0) begin
         $display("FAIL async_reset pc=%h sel=%b valid=%b required 0 0 0", pc, sel, instr_valid);
         errors++;
      end
`ifdef PC_REDIRECT_COUNT_EN
      checks++;
      if (redirect_count !== 16'd0) begin
         $display("FAIL count_reset count=%0d required 0", redirect_count);
         errors++;
      end
`endif
      $display("reset in bubble: pc=%h valid=%b", pc, instr_valid);
      tick();
      busywait = 1'b1;
      reset_n  = 1'b1;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || pc !== 32'h0) begin
         $display("FAIL idle_busy valid=%b pc=%h required 0 0", instr_valid, pc);
         errors++;
      end
      busywait = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h0) begin
         $display("FAIL idle_release valid=%b pc=%h required 1 0", instr_valid, pc);
         errors++;
      end
      $display("run: pc=%h valid=%b", pc, instr_valid);
   endtask

   // JUMP and BRANCH together with ZERO=0 still taken; offset -1 targets PC itself.
   task automatic test_jump_and_branch();
      jump   = 1'b1;
      branch = 1'b1;
      zero   = 1'b0;
      offset = 8'hFF;
      #1;
      checks++;
      if (sel !== 1'b1 || pcin !== 32'h0) begin
         $display("FAIL jump_branch sel=%b pcin=%h required 1 0", sel, pcin);
         errors++;
      end
      tick();
      checks++;
      if (pc !== 32'h0 || instr_valid !== 1'b0) begin
         $display("FAIL jump_branch_bubble pc=%h valid=%b required 0 0", pc, instr_valid);
         errors++;
      end
      $display("jump+branch: pc=%h valid=%b", pc, instr_valid);
      jump   = 1'b0;
      branch = 1'b0;
      offset = 8'h00;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_taken_branch();
      test_not_taken_branch();
      test_stall_jump();
      test_wrap();
      test_reset_in_redirect();
      test_jump_and_branch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
